// File: rtl/ov7670_pkg.sv
// Shared constants for the OV7670-style frame source: FSM encoding, pattern
// selectors and the colour-bar table.
package ov7670_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_VSYNC  = 3'd1;
  localparam state_t ST_VBACK  = 3'd2;
  localparam state_t ST_ACTIVE = 3'd3;
  localparam state_t ST_VFRONT = 3'd4;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_GRAD  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  // Index 0 is the leftmost bar.
  localparam logic [7:0][11:0] BAR_RGB = {12'hFFF, 12'hF0F, 12'h0FF, 12'hFF0,
                                          12'h00F, 12'h0F0, 12'hF00, 12'h000};

  // First byte of a pixel carries R, second carries {G,B}.
  function automatic logic [7:0] rgb_byte(input logic [11:0] rgb, input logic second);
    return second ? rgb[7:0] : {4'h0, rgb[11:8]};
  endfunction

endpackage

// File: rtl/ov7670_frame_source_if.sv
// Camera-side bus of the frame source: pixel clock, syncs and data byte.
interface ov7670_frame_source_if;
  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] D;

  modport master (output pclk, vsync, href, D);
  modport slave  (input  pclk, vsync, href, D);
endinterface

// File: rtl/ov7670_pattern_gen.sv
// Test-pattern colour lookup; the colour is registered on the tick that the
// frame FSM moves to the coordinates presented on x_i/y_i.
module ov7670_pattern_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE_PX = 320
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        tick_i,
  input  logic [15:0] x_i,
  input  logic [4:0]  y_i,
  input  logic [1:0]  pattern_i,
  input  logic [11:0] solid_i,
  output logic [11:0] rgb_o
);

  localparam int BAR_W = (H_ACTIVE_PX / 8 > 0) ? H_ACTIVE_PX / 8 : 1;

  logic [15:0] bar;
  logic [11:0] rgb_d, rgb_q;

  always_comb begin
    bar   = x_i / 16'(BAR_W);
    rgb_d = solid_i;
    unique case (pattern_i)
      PAT_BARS:  rgb_d = BAR_RGB[(bar > 16'd7) ? 3'd7 : bar[2:0]];
      PAT_GRAD:  rgb_d = {x_i[3:0], y_i[3:0], x_i[7:4]};
      PAT_CHECK: rgb_d = (x_i[4] ^ y_i[4]) ? 12'h000 : 12'hFFF;
      default:   rgb_d = solid_i;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)    rgb_q <= 12'h000;
    else if (tick_i) rgb_q <= rgb_d;
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/ov7670_frame_source.sv
// Synthetic OV7670 camera: generates pclk, vsync, href and RGB444 bytes.
//
// state  | meaning
// IDLE   | bus quiet, waits for enable on a tick
// VSYNC  | vsync high for VSYNC_LN lines
// VBACK  | back porch; pattern and solid colour captured on entry
// ACTIVE | href high for the first 2*H_ACTIVE_PX ticks of each line
// VFRONT | front porch; leaving it pulses frame_done
module ov7670_frame_source
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE_PX   = 320,
  parameter int V_ACTIVE_LN   = 240,
  parameter int H_BLANK_BYTES = 144,
  parameter int VSYNC_LN      = 3,
  parameter int VBACK_LN      = 17,
  parameter int VFRONT_LN     = 10
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_rgb,
  output logic        frame_done,
  output logic [15:0] frame_count,
  ov7670_frame_source_if.master cam
);

  localparam logic [15:0] LINE_TICKS = 16'(2 * H_ACTIVE_PX + H_BLANK_BYTES);
  localparam logic [15:0] HREF_TICKS = 16'(2 * H_ACTIVE_PX);
  localparam logic [15:0] VSYNC_TC   = 16'(VSYNC_LN - 1);
  localparam logic [15:0] VBACK_TC   = 16'(VBACK_LN - 1);
  localparam logic [15:0] ACTIVE_TC  = 16'(V_ACTIVE_LN - 1);
  localparam logic [15:0] VFRONT_TC  = 16'(VFRONT_LN - 1);

  logic        pclk_q;
  state_t      state_q, state_d;
  logic [15:0] byte_q, byte_d;
  logic [15:0] left_q, left_d;
  logic [1:0]  pat_q, pat_d;
  logic [11:0] solid_q, solid_d;
  logic        done_q, done_d;
  logic [15:0] count_q, count_d;
  logic        tick;
  logic        href_w;
  logic [4:0]  y_d;
  logic [11:0] rgb;

  // A tick is the edge on which pclk falls, so outputs settle before it rises.
  assign tick = pclk_q;

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    left_d  = left_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    done_d  = 1'b0;
    count_d = count_q;
    if (tick) begin
      if (state_q == ST_IDLE) begin
        if (enable) begin
          state_d = ST_VSYNC;
          byte_d  = 16'd0;
          left_d  = VSYNC_TC;
        end
      end else if (byte_q != LINE_TICKS - 16'd1) begin
        byte_d = byte_q + 16'd1;
      end else begin
        byte_d = 16'd0;
        if (left_q != 16'd0) begin
          left_d = left_q - 16'd1;
        end else begin
          unique case (state_q)
            ST_VSYNC: begin
              state_d = ST_VBACK;
              left_d  = VBACK_TC;
              pat_d   = pattern_sel;
              solid_d = solid_rgb;
            end
            ST_VBACK: begin
              state_d = ST_ACTIVE;
              left_d  = ACTIVE_TC;
            end
            ST_ACTIVE: begin
              state_d = ST_VFRONT;
              left_d  = VFRONT_TC;
            end
            ST_VFRONT: begin
              state_d = enable ? ST_VSYNC : ST_IDLE;
              left_d  = enable ? VSYNC_TC : 16'd0;
              done_d  = 1'b1;
              count_d = count_q + 16'd1;
            end
            default: begin
              state_d = ST_IDLE;
              left_d  = 16'd0;
            end
          endcase
        end
      end
    end
  end

  // Lines count down in ACTIVE, so the row index is the distance from the top.
  assign y_d = (state_d == ST_ACTIVE) ? 5'(ACTIVE_TC - left_d) : 5'd0;

  ov7670_pattern_gen #(.H_ACTIVE_PX(H_ACTIVE_PX)) u_pattern (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .tick_i    (tick),
    .x_i       ({1'b0, byte_d[15:1]}),
    .y_i       (y_d),
    .pattern_i (pat_q),
    .solid_i   (solid_q),
    .rgb_o     (rgb)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      pclk_q  <= 1'b0;
      state_q <= ST_IDLE;
      byte_q  <= 16'd0;
      left_q  <= 16'd0;
      pat_q   <= 2'd0;
      solid_q <= 12'h000;
      done_q  <= 1'b0;
      count_q <= 16'd0;
    end else begin
      pclk_q  <= ~pclk_q;
      state_q <= state_d;
      byte_q  <= byte_d;
      left_q  <= left_d;
      pat_q   <= pat_d;
      solid_q <= solid_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign href_w      = (state_q == ST_ACTIVE) && (byte_q < HREF_TICKS);
  assign cam.pclk    = pclk_q;
  assign cam.vsync   = (state_q == ST_VSYNC);
  assign cam.href    = href_w;
  assign cam.D       = href_w ? rgb_byte(rgb, byte_q[0]) : 8'h00;
  assign frame_done  = done_q;
  assign frame_count = count_q;

endmodule

// File: doc/ov7670_frame_source.md
OV7670_FRAME_SOURCE -- requirements
Module: ov7670_frame_source

Interface
REQ-001 Parameter H_ACTIVE_PX, default 320, meaning active pixels per line.
REQ-002 Parameter V_ACTIVE_LN, default 240, meaning active lines per frame.
REQ-003 Parameter H_BLANK_BYTES, default 144, meaning pclk periods with href low after each active line.
REQ-004 Parameter VSYNC_LN / VBACK_LN / VFRONT_LN, defaults 3 / 17 / 10, meaning line counts of the vsync pulse, back porch and front porch.
REQ-005 Clk  input  1  system clock; all logic on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  frames start only while high.
REQ-008 pattern_sel  input  2  0 colour bars, 1 gradient, 2 checkerboard, 3 solid.
REQ-009 solid_rgb  input  12  {R,G,B} 4 bits each, used when pattern_sel=3.
REQ-010 pclk  output  1  generated pixel clock, Clk/2.
REQ-011 vsync  output  1  frame sync, active high.
REQ-012 href  output  1  line-valid, active high.
REQ-013 D  output  8  camera data bus.
REQ-014 frame_done  output  1  one-Clk pulse at end of each frame.
REQ-015 frame_count  output  16  completed frames, wraps at 65535->0.

Function
REQ-016 The block SHALL toggle pclk every Clk cycle; a "tick" is the Clk edge on which pclk goes 1->0, and vsync, href and D SHALL change only on ticks (stable at pclk rising edge).
REQ-017 The FSM SHALL have states IDLE, VSYNC, VBACK, ACTIVE, VFRONT; one line = 2*H_ACTIVE_PX + H_BLANK_BYTES ticks in every non-IDLE state.
REQ-018 IDLE->VSYNC at a tick with enable=1; VSYNC->VBACK after VSYNC_LN lines; VBACK->ACTIVE after VBACK_LN lines; ACTIVE->VFRONT after V_ACTIVE_LN lines; VFRONT->VSYNC if enable=1 else IDLE, after VFRONT_LN lines.
REQ-019 vsync SHALL be high exactly during VSYNC; href SHALL be high only in ACTIVE for the first 2*H_ACTIVE_PX ticks of each line.
REQ-020 Each pixel SHALL be sent as two bytes: first {4'b0000,R}, second {G,B}; D SHALL be 8'h00 whenever href is low.
REQ-021 Pattern 0: eight vertical bars of H_ACTIVE_PX/8 px, colours in order 000,F00,0F0,00F,FF0,0FF,F0F,FFF (12-bit hex).
REQ-022 Pattern 1: R=x[3:0], G=y[3:0], B=x[7:4] (x pixel column, y active line).
REQ-023 Pattern 2: 16x16 checkerboard, FFF when x[4]^y[4]=0 else 000.
REQ-024 pattern_sel and solid_rgb SHALL be sampled at the VSYNC->VBACK transition and held for the frame.
REQ-025 frame_done SHALL pulse on the tick leaving VFRONT; frame_count SHALL increment on the same cycle.
REQ-026 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame completes, then IDLE.

Reset
REQ-027 On reset_n low, immediately: pclk=0, vsync=0, href=0, D=8'h00, frame_done=0, frame_count=0, FSM=IDLE, all counters 0.
REQ-028 Reset assertion mid-line SHALL abort the frame; after release the first frame starts with a full VSYNC.

Structure
REQ-029 State enum and colour-bar constant table SHALL live in shared package ov7670_pkg.
REQ-030 Pattern lookup SHALL be a sub-module ov7670_pattern_gen (x, y, pattern, solid -> 12-bit RGB), registered one tick ahead of use.

Verification
REQ-031 Reset release, enable=1, defaults: vsync high for exactly 3*784=2352 ticks, first href rise 17*784 ticks after vsync fall.
REQ-032 Pattern 0: first line bytes: 40 pixels of 00,00 then 0F,00; pixel 319 bytes 0F,FF; 240 href pulses of 640 ticks each.
REQ-033 Pattern 3, solid_rgb=12'hA5C: every active byte pair 0A,5C; pattern_sel changed mid-frame has no effect until next frame.
REQ-034 enable dropped during line 100: frame completes, frame_done pulses once, frame_count=1, FSM stays IDLE, outputs idle.
REQ-035 reset_n pulsed during ACTIVE: all outputs 0 within same Clk cycle; restart begins with vsync; frame_count=0.
REQ-036 Loopback into the team's pixel capture block: captured frame of pattern 1 matches expected RGB at all 76800 addresses.
